// File: rtl/voice_mix_if.sv
// Voice/codec handshake bundle for voice_mix_sequencer; the sequencer takes the slave view.
// No storage, no backpressure of its own.
interface voice_mix_if #(
   parameter int NUM_VOICES = 3,
   parameter int SAMPLE_W   = 18
);
   logic                           new_frame;
   logic                           play;
   logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
   logic [NUM_VOICES-1:0]          voice_ready;
   logic [2*NUM_VOICES-1:0]        voice_gain;
   logic [NUM_VOICES-1:0]          voice_mute;
   logic                           generate_next_sample;
   logic                           beat;
   logic [SAMPLE_W-1:0]            mixed_sample;
   logic                           sample_ready;
   logic                           clipped;
   logic                           voice_timeout;
   logic                           frame_overrun;

   modport master (
      output new_frame, play, voice_sample, voice_ready, voice_gain, voice_mute,
      input  generate_next_sample, beat, mixed_sample, sample_ready, clipped,
             voice_timeout, frame_overrun
   );

   modport slave (
      input  new_frame, play, voice_sample, voice_ready, voice_gain, voice_mute,
      output generate_next_sample, beat, mixed_sample, sample_ready, clipped,
             voice_timeout, frame_overrun
   );
endinterface

// File: rtl/voice_mix_sequencer.sv
// Per-frame voice collector/mixer: sample_ready NUM_VOICES+1 cycles after the last capture.
// No backpressure: frame edges outside IDLE are dropped and flagged; late voices are zeroed on timeout.
module voice_mix_sequencer #(
   parameter int NUM_VOICES = 3,
   parameter int SAMPLE_W   = 18,
   parameter int BEAT_COUNT = 1000,
   parameter int BEAT_W     = 10,
   parameter int TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       reset,
   voice_mix_if.slave bus
);
   localparam int ACC_W = SAMPLE_W + 3;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {4'b0000, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {4'b1111, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUM, S_OUT} state_t;

   state_t                     state_q, state_d;
   logic                       nf_q, nf_d;
   logic [NUM_VOICES-1:0]      cap_q, cap_d;
   logic signed [SAMPLE_W-1:0] smp_q [NUM_VOICES];
   logic signed [SAMPLE_W-1:0] smp_d [NUM_VOICES];
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic                       gen_q, gen_d;
   logic                       beat_q, beat_d;
   logic [SAMPLE_W-1:0]        mixed_q, mixed_d;
   logic                       srdy_q, srdy_d;
   logic                       clip_q, clip_d;
   logic                       ovr_q, ovr_d;

   logic                       frame_edge;
   logic [NUM_VOICES-1:0]      cap_set;
   logic                       all_done;
   logic                       tmo_hit;
   logic                       last_voice;

   logic                       start_frame;
   logic                       overrun;
   logic                       collect_en;
   logic                       sum_en;
   logic                       sum_last;
   logic                       out_clr;
   logic                       tmo_pulse;

   logic signed [SAMPLE_W-1:0] sel_smp;
   logic [1:0]                 sel_gain;
   logic                       sel_use;
   logic signed [ACC_W-1:0]    term_ext;
   logic signed [ACC_W-1:0]    term_shift;

   assign frame_edge = bus.new_frame & ~nf_q;
   assign cap_set    = bus.voice_ready & ~bus.voice_mute & ~cap_q;
   // Muted voices count as done, so an all-muted frame leaves COLLECT after one cycle.
   assign all_done   = &(cap_q | cap_set | bus.voice_mute);
   assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
   assign last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (frame_edge) state_d = S_COLLECT;
         S_COLLECT: if (all_done || tmo_hit) state_d = S_SUM;
         S_SUM:     if (last_voice) state_d = S_OUT;
         S_OUT:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_frame = 1'b0;
      overrun     = 1'b0;
      collect_en  = 1'b0;
      sum_en      = 1'b0;
      sum_last    = 1'b0;
      out_clr     = 1'b0;
      tmo_pulse   = 1'b0;
      case (state_q)
         S_IDLE: start_frame = frame_edge;
         S_COLLECT: begin
            overrun    = frame_edge;
            collect_en = 1'b1;
            tmo_pulse  = tmo_hit & ~all_done;
         end
         S_SUM: begin
            overrun  = frame_edge;
            sum_en   = 1'b1;
            sum_last = last_voice;
         end
         S_OUT: begin
            overrun = frame_edge;
            out_clr = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      sel_smp    = smp_q[idx_q];
      sel_gain   = bus.voice_gain[idx_q*2 +: 2];
      sel_use    = cap_q[idx_q] & ~bus.voice_mute[idx_q] & bus.play;
      term_ext   = {{3{sel_smp[SAMPLE_W-1]}}, sel_smp};
      term_shift = term_ext >>> sel_gain;
   end

   always_comb begin
      nf_d       = bus.new_frame;
      cap_d      = cap_q;
      smp_d      = smp_q;
      tmo_d      = '0;
      idx_d      = '0;
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
      beat_d     = 1'b0;
      gen_d      = start_frame;
      ovr_d      = overrun;
      mixed_d    = mixed_q;
      srdy_d     = 1'b0;
      clip_d     = 1'b0;

      if (collect_en) begin
         cap_d = cap_q | cap_set;
         tmo_d = tmo_q + TMO_W'(1);
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (cap_set[i]) smp_d[i] = bus.voice_sample[i*SAMPLE_W +: SAMPLE_W];
         end
      end

      if (sum_en) begin
         acc_d = acc_q + (sel_use ? term_shift : '0);
         idx_d = last_voice ? '0 : idx_q + IDX_W'(1);
      end

      // Final accumulation is clamped on the way into the output register.
      if (sum_last) begin
         srdy_d = 1'b1;
         if (acc_d > SAT_MAX) begin
            mixed_d = SAT_MAX[SAMPLE_W-1:0];
            clip_d  = 1'b1;
         end else if (acc_d < SAT_MIN) begin
            mixed_d = SAT_MIN[SAMPLE_W-1:0];
            clip_d  = 1'b1;
         end else begin
            mixed_d = acc_d[SAMPLE_W-1:0];
         end
      end

      if (out_clr) begin
         acc_d = '0;
         cap_d = '0;
      end

      if (start_frame && bus.play) begin
         if (beat_cnt_q == BEAT_W'(BEAT_COUNT - 1)) begin
            beat_cnt_d = '0;
            beat_d     = 1'b1;
         end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nf_q       <= 1'b0;
         cap_q      <= '0;
         tmo_q      <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         beat_cnt_q <= '0;
         gen_q      <= 1'b0;
         beat_q     <= 1'b0;
         mixed_q    <= '0;
         srdy_q     <= 1'b0;
         clip_q     <= 1'b0;
         ovr_q      <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) smp_q[i] <= '0;
      end else begin
         nf_q       <= nf_d;
         cap_q      <= cap_d;
         tmo_q      <= tmo_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         beat_cnt_q <= beat_cnt_d;
         gen_q      <= gen_d;
         beat_q     <= beat_d;
         mixed_q    <= mixed_d;
         srdy_q     <= srdy_d;
         clip_q     <= clip_d;
         ovr_q      <= ovr_d;
         for (int i = 0; i < NUM_VOICES; i++) smp_q[i] <= smp_d[i];
      end
   end

   assign bus.generate_next_sample = gen_q;
   assign bus.beat                 = beat_q;
   assign bus.mixed_sample         = mixed_q;
   assign bus.sample_ready         = srdy_q;
   assign bus.clipped              = clip_q;
   assign bus.voice_timeout        = tmo_pulse;
   assign bus.frame_overrun        = ovr_q;
endmodule
